// File: rtl/rotate_issue_ctrl.sv
// Sequential front-end for the 16-bit combinational rotate-right stage: buffers
// requests in a small FIFO, drives the rotator and registers its result.
module rotate_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int AMT_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_sweep,
  output logic [DATA_W-1:0] rot_data,
  output logic [AMT_W-1:0]  rot_amt,
  input  logic [DATA_W-1:0] rot_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic [AMT_W-1:0]  out_amt,
  output logic              out_last,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + AMT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SWEEP = 2'd2
  } state_t;

  logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  state_t            state_r;
  logic [DATA_W-1:0] op_data_r;
  logic [AMT_W-1:0]  cur_amt_r;
  logic              out_valid_r, out_last_r;
  logic [DATA_W-1:0] out_f_r;
  logic [AMT_W-1:0]  out_amt_r;

  logic              push_s, pop_s, capture_s, sweep_end_s;
  logic [DATA_W-1:0] head_data_s;
  logic [AMT_W-1:0]  head_amt_s;
  logic              head_sweep_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return {PTR_W{1'b0}};
    else                             return p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready    = (count_r != CNT_W'(FIFO_DEPTH));
  assign push_s      = in_valid && in_ready;
  assign pop_s       = (state_r == IDLE) && (count_r != {CNT_W{1'b0}});
  assign capture_s   = (state_r != IDLE) && (!out_valid_r || out_ready);
  assign sweep_end_s = (cur_amt_r == {AMT_W{1'b1}});

  assign {head_data_s, head_amt_s, head_sweep_s} = fifo_mem_r[rd_ptr_r];

  assign rot_data  = op_data_r;
  assign rot_amt   = cur_amt_r;
  assign out_valid = out_valid_r;
  assign out_f     = out_f_r;
  assign out_amt   = out_amt_r;
  assign out_last  = out_last_r;
  assign busy      = (count_r != {CNT_W{1'b0}}) || (state_r != IDLE) || out_valid_r;

  // Request FIFO storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {in_data, in_amt, in_sweep};
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM plus output register; a capture and a drain may share a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_data_r   <= {DATA_W{1'b0}};
      cur_amt_r   <= {AMT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_f_r     <= {DATA_W{1'b0}};
      out_amt_r   <= {AMT_W{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            op_data_r <= head_data_s;
            if (head_sweep_s) begin
              cur_amt_r <= {AMT_W{1'b0}};
              state_r   <= SWEEP;
            end else begin
              cur_amt_r <= head_amt_s;
              state_r   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (capture_s) state_r <= IDLE;
        end
        SWEEP: begin
          if (capture_s) begin
            if (sweep_end_s) state_r <= IDLE;
            else             cur_amt_r <= cur_amt_r + {{(AMT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= IDLE;
      endcase

      if (capture_s) begin
        out_f_r     <= rot_f;
        out_amt_r   <= cur_amt_r;
        out_valid_r <= 1'b1;
        out_last_r  <= (state_r == ISSUE) || sweep_end_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotate_issue_ctrl.sv
// Directed self-checking bench for rotate_issue_ctrl; the bench itself plays
// the external combinational rotate-right stage.
module tb_rotate_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sweep;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [15:0] rot_data, rot_f, out_f;
  logic [3:0]  rot_amt, out_amt;
  logic        out_valid, out_ready, out_last, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ror16(input logic [15:0] d, input logic [3:0] a);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < 16; i++) if (i < int'(a)) r = {r[0], r[15:1]};
    return r;
  endfunction

  assign rot_f = ror16(rot_data, rot_amt);

  rotate_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_sweep(in_sweep),
    .rot_data(rot_data), .rot_amt(rot_amt), .rot_f(rot_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_amt(out_amt), .out_last(out_last), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [15:0] d, input logic [3:0] a, input logic s);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_amt   = a;
    in_sweep = s;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check_eq("push_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else           step();
    end
    check_eq("out_valid_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_f"},     {16'd0, out_f}, 32'd0);
    check_eq({tag, "_out_amt"},   {28'd0, out_amt}, 32'd0);
    check_eq({tag, "_out_last"},  {31'd0, out_last}, 32'd0);
    check_eq({tag, "_rot_data"},  {16'd0, rot_data}, 32'd0);
    check_eq({tag, "_rot_amt"},   {28'd0, rot_amt}, 32'd0);
    check_eq({tag, "_busy"},      {31'd0, busy}, 32'd0);
  endtask

  logic [15:0] exp_f;
  logic [15:0] fifo_exp [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_amt = 4'h0;
    in_sweep = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // Single request: latency and busy fall
    out_ready = 1'b1;
    push_req(16'h1234, 4'd4, 1'b0);
    check_eq("single_e0_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("single_e1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("single_e2_valid", {31'd0, out_valid}, 32'd1);
    check_eq("single_f",    {16'd0, out_f}, 32'h4123);
    check_eq("single_amt",  {28'd0, out_amt}, 32'd4);
    check_eq("single_last", {31'd0, out_last}, 32'd1);
    check_eq("single_busy", {31'd0, busy}, 32'd1);
    step();
    check_eq("single_drained", {31'd0, out_valid}, 32'd0);
    check_eq("single_busy_fall", {31'd0, busy}, 32'd0);

    // Zero amount
    push_req(16'hBEEF, 4'd0, 1'b0);
    wait_valid();
    check_eq("zero_f",    {16'd0, out_f}, 32'hBEEF);
    check_eq("zero_last", {31'd0, out_last}, 32'd1);
    step();

    // Full sweep of 0x0001, back-to-back beats
    push_req(16'h0001, 4'd0, 1'b1);
    exp_f = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) check_eq("sweep_b2b", {31'd0, out_valid}, 32'd1);
      wait_valid();
      check_eq("sweep_f",    {16'd0, out_f}, {16'd0, exp_f});
      check_eq("sweep_amt",  {28'd0, out_amt}, k);
      check_eq("sweep_last", {31'd0, out_last}, (k == 15) ? 32'd1 : 32'd0);
      exp_f = {exp_f[0], exp_f[15:1]};
      step();
    end
    check_eq("sweep_end_valid", {31'd0, out_valid}, 32'd0);
    check_eq("sweep_end_busy",  {31'd0, busy}, 32'd0);

    // Sweep of 0x00F0 with backpressure held at amount 6
    push_req(16'h00F0, 4'd0, 1'b1);
    exp_f = 16'h00F0;
    for (int k = 0; k < 16; k++) begin
      wait_valid();
      check_eq("bp_f",   {16'd0, out_f}, {16'd0, exp_f});
      check_eq("bp_amt", {28'd0, out_amt}, k);
      if (k == 6) begin
        check_eq("bp_f6", {16'd0, out_f}, 32'hC003);
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          check_eq("bp_hold_f",     {16'd0, out_f}, 32'hC003);
          check_eq("bp_hold_amt",   {28'd0, out_amt}, 32'd6);
          check_eq("bp_hold_last",  {31'd0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
      end
      if (k == 7) check_eq("bp_f7", {16'd0, out_f}, 32'hE001);
      exp_f = {exp_f[0], exp_f[15:1]};
      step();
    end
    check_eq("bp_end_valid", {31'd0, out_valid}, 32'd0);

    // FIFO full under backpressure, then in-order drain
    out_ready = 1'b0;
    fifo_exp[0] = 16'h4123; fifo_exp[1] = 16'hBEEF;
    fifo_exp[2] = 16'hC000; fifo_exp[3] = 16'hC003;
    push_req(16'h1234, 4'd4, 1'b0);
    push_req(16'hBEEF, 4'd0, 1'b0);
    push_req(16'h8001, 4'd1, 1'b0);
    push_req(16'h00F0, 4'd6, 1'b0);
    check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("full_out_f",    {16'd0, out_f}, 32'h4123);
    check_eq("full_rot_data", {16'd0, rot_data}, 32'hBEEF);
    check_eq("full_busy",     {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid();
      check_eq("drain_f",    {16'd0, out_f}, {16'd0, fifo_exp[k]});
      check_eq("drain_last", {31'd0, out_last}, 32'd1);
      step();
    end
    check_eq("drain_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("drain_busy",     {31'd0, busy}, 32'd0);

    // Reset in the middle of a sweep
    push_req(16'h0001, 4'd0, 1'b1);
    wait_valid();
    for (int i = 0; i < 40 && !(out_valid && out_amt == 4'd9); i++) step();
    check_eq("midrst_reached9", {28'd0, out_amt}, 32'd9);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
    push_req(16'h8001, 4'd1, 1'b0);
    wait_valid();
    check_eq("post_rst_f",    {16'd0, out_f}, 32'hC000);
    check_eq("post_rst_amt",  {28'd0, out_amt}, 32'd1);
    check_eq("post_rst_last", {31'd0, out_last}, 32'd1);
    step();
    check_eq("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
